// File: rtl/qrs_beat_tracker_if.sv
// Sample-stream bundle between the adaptive-threshold stage and the beat tracker.
//
// Handshake: sample_en is a one-cycle valid strobe with no ready. The tracker
// accepts every strobed sample, so a producer may assert sample_en on
// consecutive cycles. qrs_in is meaningful only while sample_en is high.
// The tracker never stalls the producer.
interface qrs_beat_tracker_if;
   logic        sample_en;
   logic        qrs_in;
   logic        beat_pulse;
   logic [15:0] rr_interval;
   logic [15:0] rr_avg;
   logic        avg_valid;
   logic        asystole;
   logic [15:0] beat_count;
   logic [1:0]  state_dbg;    // FSM state: 0 ARM, 1 CONFIRM, 2 REFRACTORY

   // Producer side: drives samples and observes results.
   modport master (
      output sample_en, qrs_in,
      input  beat_pulse, rr_interval, rr_avg, avg_valid, asystole, beat_count, state_dbg
   );

   // Tracker side: consumes samples and produces results.
   modport slave (
      input  sample_en, qrs_in,
      output beat_pulse, rr_interval, rr_avg, avg_valid, asystole, beat_count, state_dbg
   );
endinterface

// File: rtl/qrs_beat_tracker.sv
// QRS beat tracker. It debounces the raw detection bit, applies a refractory
// window after each beat and measures R-R intervals in samples. It keeps an
// 8-beat running average and raises asystole when beats stop arriving.
module qrs_beat_tracker #(
   parameter int REFRACT = 50,
   parameter int MIN_RUN = 3,
   parameter int TIMEOUT = 3000
) (
   input logic                clk,
   input logic                rst,
   qrs_beat_tracker_if.slave  bus
);

   typedef enum logic [1:0] {
      ARM        = 2'd0,
      CONFIRM    = 2'd1,
      REFRACTORY = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  run;
   logic [15:0] ref_cnt;
   logic [15:0] rr_cnt;
   logic        first;
   logic [15:0] hist [8];
   logic [2:0]  wr_ptr;
   logic [3:0]  fill;
   logic [18:0] sum;
   logic        avg_upd;

   logic        beat_pulse_q;
   logic [15:0] rr_interval_q;
   logic [15:0] rr_avg_q;
   logic        avg_valid_q;
   logic        asystole_q;
   logic [15:0] beat_count_q;

   logic [3:0]  run_inc;
   logic [15:0] rr_inc;
   logic        beat_now;
   logic        timeout_hit;

   // Next-sample arithmetic and event detection for the current sample.
   always_comb begin
      run_inc     = run + 4'd1;
      rr_inc      = (rr_cnt == 16'hFFFF) ? rr_cnt : rr_cnt + 16'd1;
      beat_now    = 1'b0;
      timeout_hit = 1'b0;
      if (bus.sample_en && bus.qrs_in) begin
         if (state == ARM && MIN_RUN == 1)
            beat_now = 1'b1;
         else if (state == CONFIRM && run_inc == 4'(MIN_RUN))
            beat_now = 1'b1;
      end
      // A beat on the same sample wins over the timeout.
      if (bus.sample_en && !first && !beat_now && rr_inc == 16'(TIMEOUT))
         timeout_hit = 1'b1;
   end

   // Debounce / refractory state machine.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ARM;
         run     <= 4'd0;
         ref_cnt <= 16'd0;
      end else if (bus.sample_en) begin
         case (state)
            ARM: begin
               if (bus.qrs_in) begin
                  if (MIN_RUN == 1) begin
                     state   <= REFRACTORY;
                     run     <= 4'd0;
                     ref_cnt <= 16'd0;
                  end else begin
                     state <= CONFIRM;
                     run   <= 4'd1;
                  end
               end
            end
            CONFIRM: begin
               if (!bus.qrs_in) begin
                  state <= ARM;
                  run   <= 4'd0;
               end else if (run_inc == 4'(MIN_RUN)) begin
                  state   <= REFRACTORY;
                  run     <= 4'd0;
                  ref_cnt <= 16'd0;
               end else begin
                  run <= run_inc;
               end
            end
            REFRACTORY: begin
               // qrs_in is ignored; leave after REFRACT samples.
               if (ref_cnt + 16'd1 == 16'(REFRACT)) begin
                  state   <= ARM;
                  ref_cnt <= 16'd0;
               end else begin
                  ref_cnt <= ref_cnt + 16'd1;
               end
            end
            default: state <= ARM;
         endcase
      end
   end

   // Interval counting, beat bookkeeping, history and asystole detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_cnt        <= 16'd0;
         first         <= 1'b1;
         wr_ptr        <= 3'd0;
         fill          <= 4'd0;
         sum           <= 19'd0;
         avg_upd       <= 1'b0;
         beat_pulse_q  <= 1'b0;
         rr_interval_q <= 16'd0;
         asystole_q    <= 1'b0;
         beat_count_q  <= 16'd0;
         for (int i = 0; i < 8; i++) hist[i] <= 16'd0;
      end else begin
         beat_pulse_q <= 1'b0;
         avg_upd      <= 1'b0;
         if (bus.sample_en) begin
            rr_cnt <= beat_now ? 16'd0 : rr_inc;
            if (beat_now) begin
               beat_pulse_q <= 1'b1;
               if (beat_count_q != 16'hFFFF) beat_count_q <= beat_count_q + 16'd1;
               if (first) begin
                  // No previous beat to measure from.
                  first      <= 1'b0;
                  asystole_q <= 1'b0;
               end else begin
                  rr_interval_q <= rr_inc;
                  hist[wr_ptr]  <= rr_inc;
                  wr_ptr        <= wr_ptr + 3'd1;
                  // Evicted slot reads 0 until the history has filled once.
                  sum           <= sum + {3'b000, rr_inc} - {3'b000, hist[wr_ptr]};
                  if (fill != 4'd8) fill <= fill + 4'd1;
                  avg_upd       <= 1'b1;
               end
            end else if (timeout_hit) begin
               // rr_interval and rr_avg deliberately keep their last values.
               asystole_q   <= 1'b1;
               first        <= 1'b1;
               beat_count_q <= 16'd0;
               wr_ptr       <= 3'd0;
               fill         <= 4'd0;
               sum          <= 19'd0;
               for (int i = 0; i < 8; i++) hist[i] <= 16'd0;
            end
         end
      end
   end

   // Average output stage, one clock behind the sum register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_avg_q    <= 16'd0;
         avg_valid_q <= 1'b0;
      end else begin
         avg_valid_q <= (fill == 4'd8);
         if (avg_upd) rr_avg_q <= sum[18:3];
      end
   end

   assign bus.beat_pulse  = beat_pulse_q;
   assign bus.rr_interval = rr_interval_q;
   assign bus.rr_avg      = rr_avg_q;
   assign bus.avg_valid   = avg_valid_q;
   assign bus.asystole    = asystole_q;
   assign bus.beat_count  = beat_count_q;
   assign bus.state_dbg   = state;

endmodule
